// File: rtl/ether_pkg.sv
// rtl/ether_pkg.sv - shared Ethernet/ARP receive constants, state and drop-code types
package ether_pkg;

  // Preamble hunt bytes
  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;

  // Ethertypes and ARP body constants for Ethernet/IPv4 ARP
  localparam logic [15:0] ETYPE_ARP     = 16'h0806;
  localparam logic [15:0] ETYPE_IPV4    = 16'h0800;
  localparam logic [15:0] ARP_HTYPE_ETH = 16'h0001;
  localparam logic [7:0]  ARP_HLEN      = 8'd6;
  localparam logic [7:0]  ARP_PLEN      = 8'd4;
  localparam logic [47:0] MAC_BCAST     = 48'hFFFF_FFFF_FFFF;

  // Reflected CRC-32; a frame with a correct FCS leaves CRC_RESIDUE behind
  localparam logic [31:0] CRC_POLY      = 32'hEDB8_8320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB_20E3;

  // Shortest legal frame, destination MAC through FCS
  localparam logic [10:0] MIN_FRAME_LEN = 11'd64;

  // Byte offsets counted from the first byte after the SFD
  localparam logic [10:0] OFF_DST   = 11'd0;
  localparam logic [10:0] OFF_SRC   = 11'd6;
  localparam logic [10:0] OFF_ETYPE = 11'd12;
  localparam logic [10:0] OFF_HTYPE = 11'd14;
  localparam logic [10:0] OFF_PTYPE = 11'd16;
  localparam logic [10:0] OFF_HLEN  = 11'd18;
  localparam logic [10:0] OFF_PLEN  = 11'd19;
  localparam logic [10:0] OFF_OPER  = 11'd20;
  localparam logic [10:0] OFF_SHA   = 11'd22;
  localparam logic [10:0] OFF_SPA   = 11'd28;
  localparam logic [10:0] OFF_THA   = 11'd32;
  localparam logic [10:0] OFF_TPA   = 11'd38;
  localparam logic [10:0] OFF_TAIL  = 11'd42;

  typedef enum logic [2:0] {
    DROP_NONE     = 3'd0,
    DROP_RX_ERR   = 3'd1,
    DROP_PREAMBLE = 3'd2,
    DROP_RUNT     = 3'd3,
    DROP_TOO_LONG = 3'd4,
    DROP_BAD_FCS  = 3'd5,
    DROP_NOT_ARP  = 3'd6,
    DROP_NOT_US   = 3'd7
  } drop_code_e;

  typedef enum logic [2:0] {
    S_SKIP, S_IDLE, S_PRE, S_HDR, S_BODY, S_TAIL, S_EVAL, S_DROP
  } rx_state_e;

  // True when byte index idx lies in the field [lo, next)
  function automatic logic in_field(input logic [10:0] idx,
                                    input logic [10:0] lo,
                                    input logic [10:0] next);
    return (idx >= lo) && (idx < next);
  endfunction

endpackage

// File: rtl/ether_crc32_d8.sv
// rtl/ether_crc32_d8.sv - byte-wide reflected CRC-32 next-state function
module ether_crc32_d8
  import ether_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  // Fold the byte in LSB-first, then run eight reflected shift/xor steps
  always_comb begin
    logic [31:0] w_c;
    w_c = crc_in ^ {24'd0, data};
    for (int i = 0; i < 8; i++) begin
      w_c = w_c[0] ? ((w_c >> 1) ^ CRC_POLY) : (w_c >> 1);
    end
    crc_out = w_c;
  end

endmodule

// File: rtl/ether_arp_rx.sv
// rtl/ether_arp_rx.sv - GMII-style receive parser producing ARP results or drop reasons
module ether_arp_rx
  import ether_pkg::*;
#(
  parameter logic [47:0] MY_MAC    = 48'h00301ba0a48e,
  parameter logic [31:0] MY_IP     = 32'h0a001563,
  parameter logic        CHECK_FCS = 1'b1,
  parameter int unsigned MAX_LEN   = 1518
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        dv,
  input  logic        er,
  input  logic [7:0]  data,
  output logic        arp_valid,
  output logic [15:0] arp_oper,
  output logic [47:0] arp_sha,
  output logic [31:0] arp_spa,
  output logic [31:0] arp_tpa,
  output logic        frame_drop,
  output logic [2:0]  drop_code
);

  rx_state_e   r_state;
  logic [10:0] r_cnt;
  logic [31:0] r_crc;
  logic [47:0] r_dst;
  logic [15:0] r_etype;
  logic [15:0] r_htype;
  logic [15:0] r_ptype;
  logic [7:0]  r_hlen;
  logic [7:0]  r_plen;
  logic [15:0] r_oper;
  logic [47:0] r_sha;
  logic [31:0] r_spa;
  logic [31:0] r_tpa;

  logic        r_arp_valid;
  logic [15:0] r_arp_oper;
  logic [47:0] r_arp_sha;
  logic [31:0] r_arp_spa;
  logic [31:0] r_arp_tpa;
  logic        r_frame_drop;
  drop_code_e  r_drop_code;

  logic [31:0] w_crc_next;
  drop_code_e  w_eval_code;

  ether_crc32_d8 u_crc (
    .crc_in  (r_crc),
    .data    (data),
    .crc_out (w_crc_next)
  );

  // End-of-frame verdict from the captured fields; only consumed in TAIL with dv low
  always_comb begin
    w_eval_code = DROP_NONE;
    if (r_cnt < MIN_FRAME_LEN)
      w_eval_code = DROP_RUNT;
    else if (CHECK_FCS && (r_crc != CRC_RESIDUE))
      w_eval_code = DROP_BAD_FCS;
    else if ((r_etype != ETYPE_ARP) || (r_htype != ARP_HTYPE_ETH) ||
             (r_ptype != ETYPE_IPV4) || (r_hlen != ARP_HLEN) || (r_plen != ARP_PLEN))
      w_eval_code = DROP_NOT_ARP;
    else if (((r_dst != MAC_BCAST) && (r_dst != MY_MAC)) || (r_tpa != MY_IP))
      w_eval_code = DROP_NOT_US;
  end

  // Receive FSM with byte counting, CRC accumulation, field capture and result pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_SKIP;
      r_cnt        <= '0;
      r_crc        <= CRC_INIT;
      r_dst        <= '0;
      r_etype      <= '0;
      r_htype      <= '0;
      r_ptype      <= '0;
      r_hlen       <= '0;
      r_plen       <= '0;
      r_oper       <= '0;
      r_sha        <= '0;
      r_spa        <= '0;
      r_tpa        <= '0;
      r_arp_valid  <= 1'b0;
      r_arp_oper   <= '0;
      r_arp_sha    <= '0;
      r_arp_spa    <= '0;
      r_arp_tpa    <= '0;
      r_frame_drop <= 1'b0;
      r_drop_code  <= DROP_NONE;
    end else begin
      r_arp_valid  <= 1'b0;
      r_frame_drop <= 1'b0;
      r_drop_code  <= DROP_NONE;
      case (r_state)
        S_SKIP: begin
          if (!dv) r_state <= S_IDLE;
        end
        // EVAL is the result cycle; it must accept a new frame like IDLE so a one-cycle gap suffices
        S_IDLE, S_EVAL: begin
          r_state <= S_IDLE;
          if (dv) begin
            if (data == PREAMBLE_BYTE) begin
              r_state <= S_PRE;
            end else if (data == SFD_BYTE) begin
              r_state <= S_HDR;
              r_cnt   <= '0;
              r_crc   <= CRC_INIT;
            end else begin
              r_state      <= S_DROP;
              r_frame_drop <= 1'b1;
              r_drop_code  <= DROP_PREAMBLE;
            end
          end
        end
        S_PRE: begin
          if (!dv) begin
            r_state      <= S_IDLE;
            r_frame_drop <= 1'b1;
            r_drop_code  <= DROP_PREAMBLE;
          end else if (er) begin
            r_state      <= S_DROP;
            r_frame_drop <= 1'b1;
            r_drop_code  <= DROP_RX_ERR;
          end else if (data == SFD_BYTE) begin
            r_state <= S_HDR;
            r_cnt   <= '0;
            r_crc   <= CRC_INIT;
          end else if (data != PREAMBLE_BYTE) begin
            r_state      <= S_DROP;
            r_frame_drop <= 1'b1;
            r_drop_code  <= DROP_PREAMBLE;
          end
        end
        S_HDR, S_BODY, S_TAIL: begin
          if (!dv) begin
            // Frame ended: dv is already low, so any drop returns straight to IDLE
            if (r_state != S_TAIL) begin
              r_state      <= S_IDLE;
              r_frame_drop <= 1'b1;
              r_drop_code  <= DROP_RUNT;
            end else if (w_eval_code == DROP_NONE) begin
              r_state     <= S_EVAL;
              r_arp_valid <= 1'b1;
              r_arp_oper  <= r_oper;
              r_arp_sha   <= r_sha;
              r_arp_spa   <= r_spa;
              r_arp_tpa   <= r_tpa;
            end else begin
              r_state      <= S_IDLE;
              r_frame_drop <= 1'b1;
              r_drop_code  <= w_eval_code;
            end
          end else if (er) begin
            r_state      <= S_DROP;
            r_frame_drop <= 1'b1;
            r_drop_code  <= DROP_RX_ERR;
          end else if (r_cnt == 11'(MAX_LEN)) begin
            r_state      <= S_DROP;
            r_frame_drop <= 1'b1;
            r_drop_code  <= DROP_TOO_LONG;
          end else begin
            r_cnt <= r_cnt + 11'd1;
            r_crc <= w_crc_next;
            if (in_field(r_cnt, OFF_DST, OFF_SRC))     r_dst   <= {r_dst[39:0], data};
            if (in_field(r_cnt, OFF_ETYPE, OFF_HTYPE)) r_etype <= {r_etype[7:0], data};
            if (in_field(r_cnt, OFF_HTYPE, OFF_PTYPE)) r_htype <= {r_htype[7:0], data};
            if (in_field(r_cnt, OFF_PTYPE, OFF_HLEN))  r_ptype <= {r_ptype[7:0], data};
            if (r_cnt == OFF_HLEN)                     r_hlen  <= data;
            if (r_cnt == OFF_PLEN)                     r_plen  <= data;
            if (in_field(r_cnt, OFF_OPER, OFF_SHA))    r_oper  <= {r_oper[7:0], data};
            if (in_field(r_cnt, OFF_SHA, OFF_SPA))     r_sha   <= {r_sha[39:0], data};
            if (in_field(r_cnt, OFF_SPA, OFF_THA))     r_spa   <= {r_spa[23:0], data};
            if (in_field(r_cnt, OFF_TPA, OFF_TAIL))    r_tpa   <= {r_tpa[23:0], data};
            if (r_cnt == OFF_HTYPE - 11'd1)     r_state <= S_BODY;
            else if (r_cnt == OFF_TAIL - 11'd1) r_state <= S_TAIL;
          end
        end
        S_DROP: begin
          if (!dv) r_state <= S_IDLE;
        end
        default: r_state <= S_SKIP;
      endcase
    end
  end

  assign arp_valid  = r_arp_valid;
  assign arp_oper   = r_arp_oper;
  assign arp_sha    = r_arp_sha;
  assign arp_spa    = r_arp_spa;
  assign arp_tpa    = r_arp_tpa;
  assign frame_drop = r_frame_drop;
  assign drop_code  = r_drop_code;

endmodule

// File: tb/tb_ether_arp_rx.sv
// tb/tb_ether_arp_rx.sv - directed self-checking bench for ether_arp_rx
module tb_ether_arp_rx;

  logic clk = 1'b0;
  logic rst, dv, er;
  logic [7:0] data;

  logic        v0, d0, v1, d1;
  logic [15:0] op0, op1;
  logic [47:0] sha0, sha1;
  logic [31:0] spa0, spa1, tpa0, tpa1;
  logic [2:0]  dc0, dc1;

  always #5 clk = ~clk;

  ether_arp_rx #(.CHECK_FCS(1'b0)) dut0 (
    .clk(clk), .rst(rst), .dv(dv), .er(er), .data(data),
    .arp_valid(v0), .arp_oper(op0), .arp_sha(sha0), .arp_spa(spa0), .arp_tpa(tpa0),
    .frame_drop(d0), .drop_code(dc0)
  );

  ether_arp_rx #(.CHECK_FCS(1'b1)) dut1 (
    .clk(clk), .rst(rst), .dv(dv), .er(er), .data(data),
    .arp_valid(v1), .arp_oper(op1), .arp_sha(sha1), .arp_spa(spa1), .arp_tpa(tpa1),
    .frame_drop(d1), .drop_code(dc1)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: counts high cycles and remembers when/what was last seen
  int nv[2] = '{0, 0};
  int nd[2] = '{0, 0};
  int vcyc[2] = '{-1, -1};
  int dcyc[2] = '{-1, -1};
  logic [2:0] dcode[2];
  always @(negedge clk) begin
    if (v0) begin nv[0]++; vcyc[0] = cyc; end
    if (v1) begin nv[1]++; vcyc[1] = cyc; end
    if (d0) begin nd[0]++; dcyc[0] = cyc; dcode[0] = dc0; end
    if (d1) begin nd[1]++; dcyc[1] = cyc; dcode[1] = dc1; end
  end

  logic [7:0] fr [0:1599];
  int fall_cyc, mark_cyc;
  int bv0, bv1, bd0, bd1;

  task automatic drive(input logic v, input logic e, input logic [7:0] d);
    dv = v; er = e; data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    bv0 = nv[0]; bv1 = nv[1]; bd0 = nd[0]; bd1 = nd[1];
  endtask

  // Bit-serial reflected CRC-32 over fr[0..n-1], returned already complemented
  function automatic logic [31:0] fcs_of(input int n);
    logic [31:0] c;
    logic fb;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++)
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ fr[i][b];
        c = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    return ~c;
  endfunction

  task automatic build_sample();
    logic [335:0] hdr;
    hdr = {48'hFFFFFFFFFFFF, 48'h00301ba0a48e, 16'h0806, 16'h0001, 16'h0800,
           8'h06, 8'h04, 16'h0001, 48'h00301ba0a48e, 32'h0a00150a,
           48'h000000000000, 32'h0a001563};
    for (int i = 0; i < 1600; i++) fr[i] = 8'h00;
    for (int i = 0; i < 42; i++) fr[i] = hdr[335 - 8*i -: 8];
  endtask

  task automatic set_fcs(input int n, input bit good);
    logic [31:0] f;
    f = good ? fcs_of(n - 4) : 32'h0;
    fr[n-4] = f[7:0]; fr[n-3] = f[15:8]; fr[n-2] = f[23:16]; fr[n-1] = f[31:24];
  endtask

  task automatic send_frame(input int n, input int er_idx, input int stop_idx,
                            input int rst_idx, input int mark_idx);
    int last;
    for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b0, 8'hD5);
    last = (stop_idx >= 0) ? stop_idx : n - 1;
    mark_cyc = -1;
    for (int i = 0; i <= last; i++) begin
      rst = (i == rst_idx);
      drive(1'b1, (i == er_idx), fr[i]);
      if (i == mark_idx) mark_cyc = cyc;
    end
    rst = 1'b0;
    drive(1'b0, 1'b0, 8'h00);
    fall_cyc = cyc;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_reset();
    rst = 1'b1; dv = 1'b0; er = 1'b0; data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (v0 !== 1'b0)  begin fails++; $display("FAIL reset_valid got %b want 0", v0); end
    tests++; if (d0 !== 1'b0)  begin fails++; $display("FAIL reset_drop got %b want 0", d0); end
    tests++; if (dc0 !== 3'd0) begin fails++; $display("FAIL reset_code got %0d want 0", dc0); end
    tests++; if ({op0, sha0, spa0, tpa0} !== 128'h0) begin fails++; $display("FAIL reset_fields got %h want 0", {op0, sha0, spa0, tpa0}); end
    tests++; if ({v1, d1, dc1} !== 5'h0) begin fails++; $display("FAIL reset_dut1 got %h want 0", {v1, d1, dc1}); end
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_sample_zero_fcs();
    build_sample(); set_fcs(64, 1'b0); snap();
    send_frame(64, -1, -1, -1, -1); idle(2);
    tests++; if (nv[0] - bv0 !== 1) begin fails++; $display("FAIL zfcs_valid_count got %0d want 1", nv[0] - bv0); end
    tests++; if (vcyc[0] !== fall_cyc) begin fails++; $display("FAIL zfcs_valid_cycle got %0d want %0d", vcyc[0], fall_cyc); end
    tests++; if (op0 !== 16'h0001) begin fails++; $display("FAIL zfcs_oper got %h want 0001", op0); end
    tests++; if (sha0 !== 48'h00301ba0a48e) begin fails++; $display("FAIL zfcs_sha got %h want 00301ba0a48e", sha0); end
    tests++; if (spa0 !== 32'h0a00150a) begin fails++; $display("FAIL zfcs_spa got %h want 0a00150a", spa0); end
    tests++; if (tpa0 !== 32'h0a001563) begin fails++; $display("FAIL zfcs_tpa got %h want 0a001563", tpa0); end
    tests++; if (nd[0] - bd0 !== 0) begin fails++; $display("FAIL zfcs_no_drop got %0d want 0", nd[0] - bd0); end
    tests++; if (nd[1] - bd1 !== 1 || dcode[1] !== 3'd5) begin fails++; $display("FAIL zfcs_badfcs got n=%0d code=%0d want n=1 code=5", nd[1] - bd1, dcode[1]); end
    tests++; if (nv[1] - bv1 !== 0) begin fails++; $display("FAIL zfcs_dut1_no_valid got %0d want 0", nv[1] - bv1); end
  endtask

  task automatic test_good_fcs();
    build_sample(); set_fcs(64, 1'b1); snap();
    send_frame(64, -1, -1, -1, -1); idle(2);
    tests++; if (nv[1] - bv1 !== 1 || vcyc[1] !== fall_cyc) begin fails++; $display("FAIL gfcs_valid got n=%0d cyc=%0d want n=1 cyc=%0d", nv[1] - bv1, vcyc[1], fall_cyc); end
    tests++; if ({op1, sha1, spa1, tpa1} !== {16'h0001, 48'h00301ba0a48e, 32'h0a00150a, 32'h0a001563}) begin fails++; $display("FAIL gfcs_fields got %h", {op1, sha1, spa1, tpa1}); end
    tests++; if (nd[1] - bd1 !== 0) begin fails++; $display("FAIL gfcs_no_drop got %0d want 0", nd[1] - bd1); end
  endtask

  task automatic test_rx_error();
    build_sample(); fr[21] = 8'h02; set_fcs(64, 1'b1); snap();
    send_frame(64, 24, -1, -1, -1); idle(2);
    tests++; if (nd[1] - bd1 !== 1 || dcode[1] !== 3'd1) begin fails++; $display("FAIL rxerr_drop got n=%0d code=%0d want n=1 code=1", nd[1] - bd1, dcode[1]); end
    tests++; if (nv[0] - bv0 + nv[1] - bv1 !== 0) begin fails++; $display("FAIL rxerr_no_valid got %0d want 0", nv[0] - bv0 + nv[1] - bv1); end
    tests++; if (op1 !== 16'h0001 || sha1 !== 48'h00301ba0a48e) begin fails++; $display("FAIL rxerr_hold got oper=%h sha=%h want 0001 00301ba0a48e", op1, sha1); end
    tests++; if (nd[0] - bd0 !== 1 || dcode[0] !== 3'd1) begin fails++; $display("FAIL rxerr_drop_dut0 got n=%0d code=%0d want n=1 code=1", nd[0] - bd0, dcode[0]); end
  endtask

  task automatic test_filters();
    build_sample(); fr[41] = 8'h62; set_fcs(64, 1'b1); snap();
    send_frame(64, -1, -1, -1, -1); idle(2);
    tests++; if (nd[1] - bd1 !== 1 || dcode[1] !== 3'd7 || nv[1] !== bv1) begin fails++; $display("FAIL not_us got n=%0d code=%0d want n=1 code=7", nd[1] - bd1, dcode[1]); end
    build_sample(); fr[13] = 8'h00; set_fcs(64, 1'b1); snap();
    send_frame(64, -1, -1, -1, -1); idle(2);
    tests++; if (nd[1] - bd1 !== 1 || dcode[1] !== 3'd6 || nv[1] !== bv1) begin fails++; $display("FAIL not_arp got n=%0d code=%0d want n=1 code=6", nd[1] - bd1, dcode[1]); end
    tests++; if (nd[0] - bd0 !== 1 || dcode[0] !== 3'd6) begin fails++; $display("FAIL not_arp_dut0 got n=%0d code=%0d want n=1 code=6", nd[0] - bd0, dcode[0]); end
  endtask

  task automatic test_runt();
    build_sample(); snap();
    send_frame(64, -1, 40, -1, -1); idle(2);
    tests++; if (nd[0] - bd0 !== 1 || dcode[0] !== 3'd3) begin fails++; $display("FAIL runt got n=%0d code=%0d want n=1 code=3", nd[0] - bd0, dcode[0]); end
    tests++; if (dcyc[0] !== fall_cyc) begin fails++; $display("FAIL runt_cycle got %0d want %0d", dcyc[0], fall_cyc); end
    tests++; if (nv[0] - bv0 !== 0) begin fails++; $display("FAIL runt_no_valid got %0d want 0", nv[0] - bv0); end
  endtask

  task automatic test_too_long();
    build_sample(); snap();
    send_frame(1600, -1, -1, -1, 1518); idle(2);
    tests++; if (nd[0] - bd0 !== 1 || dcode[0] !== 3'd4) begin fails++; $display("FAIL long got n=%0d code=%0d want n=1 code=4", nd[0] - bd0, dcode[0]); end
    tests++; if (dcyc[0] !== mark_cyc) begin fails++; $display("FAIL long_cycle got %0d want %0d", dcyc[0], mark_cyc); end
    tests++; if (nv[0] - bv0 !== 0) begin fails++; $display("FAIL long_no_valid got %0d want 0", nv[0] - bv0); end
  endtask

  task automatic test_mid_reset();
    build_sample(); set_fcs(64, 1'b1); snap();
    send_frame(64, -1, -1, 32, -1);
    send_frame(64, -1, -1, -1, -1); idle(2);
    tests++; if (nv[1] - bv1 !== 1 || vcyc[1] !== fall_cyc) begin fails++; $display("FAIL midrst_valid got n=%0d cyc=%0d want n=1 cyc=%0d", nv[1] - bv1, vcyc[1], fall_cyc); end
    tests++; if (nd[0] - bd0 + nd[1] - bd1 !== 0) begin fails++; $display("FAIL midrst_no_drop got %0d want 0", nd[0] - bd0 + nd[1] - bd1); end
    tests++; if (spa1 !== 32'h0a00150a) begin fails++; $display("FAIL midrst_spa got %h want 0a00150a", spa1); end
  endtask

  task automatic test_back_to_back();
    build_sample(); set_fcs(64, 1'b1); snap();
    send_frame(64, -1, -1, -1, -1);
    build_sample();
    fr[0] = 8'h00; fr[1] = 8'h30; fr[2] = 8'h1b; fr[3] = 8'ha0; fr[4] = 8'ha4; fr[5] = 8'h8e;
    fr[21] = 8'h02; fr[31] = 8'h01;
    set_fcs(64, 1'b1);
    send_frame(64, -1, -1, -1, -1); idle(2);
    tests++; if (nv[1] - bv1 !== 2 || nd[1] !== bd1) begin fails++; $display("FAIL b2b_count got v=%0d d=%0d want v=2 d=0", nv[1] - bv1, nd[1] - bd1); end
    tests++; if (vcyc[1] !== fall_cyc) begin fails++; $display("FAIL b2b_cycle got %0d want %0d", vcyc[1], fall_cyc); end
    tests++; if (op1 !== 16'h0002 || spa1 !== 32'h0a001501) begin fails++; $display("FAIL b2b_fields got oper=%h spa=%h want 0002 0a001501", op1, spa1); end
  endtask

  initial begin
    test_reset();
    test_sample_zero_fcs();
    test_good_fcs();
    test_rx_error();
    test_filters();
    test_runt();
    test_too_long();
    test_mid_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
